// File: rtl/floating_point_accumulator.sv
// floating_point_accumulator: sequential FP16 adder that sums LEN operands per accumulation.
// Ports: clk, reset (synchronous, active-high), start (clears the sum and begins a new accumulation),
//        en/a/in_ready (operand handshake, in_ready high only while waiting for an operand),
//        result/ready (accumulated sum, with ready as a one-cycle valid pulse).
// Macro FP_ACC_SATURATE_EN: when defined, finite overflow saturates to +/-0x7BFF instead of +/-inf.
module floating_point_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ready
);
    localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, ALIGN = 3'd2, ADD = 3'd3, NORM = 3'd4, DONE = 3'd5;
    localparam logic [7:0] LEN_C = 8'(LEN);
`ifdef FP_ACC_SATURATE_EN
    localparam logic [14:0] OVF = 15'h7BFF;
`else
    localparam logic [14:0] OVF = 15'h7C00;
`endif

    logic [2:0]        state_q, state_d;
    logic [15:0]       sum_q, sum_d, op_q, op_d, result_q, result_d, spv_q, spv_d, nv;
    logic [7:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d, sgn_q, sgn_d, sub_q, sub_d, spc_q, spc_d;
    logic [4:0]        exp_q, exp_d, xe, ye, diff;
    logic [10:0]       mb_q, mb_d, ms_q, ms_d, xm, ym;
    logic [11:0]       add_q, add_d, nm;
    logic              xs, ys, xnan, ynan, xbig;
    logic [3:0]        p;
    logic signed [6:0] e_n;

    assign in_ready = (state_q == WAIT);
    assign result   = result_q;
    assign ready    = ready_q;

    // Alignment: zero exponents (zero or subnormal) are flushed to +0 before anything else.
    // The larger-magnitude operand is "big", so the mantissa difference is never negative.
    always_comb begin
        xe    = sum_q[14:10];
        ye    = op_q[14:10];
        xs    = sum_q[15] & (xe != 5'd0);
        ys    = op_q[15] & (ye != 5'd0);
        xm    = (xe == 5'd0) ? 11'd0 : {1'b1, sum_q[9:0]};
        ym    = (ye == 5'd0) ? 11'd0 : {1'b1, op_q[9:0]};
        xnan  = (xe == 5'd31) && (sum_q[9:0] != 10'd0);
        ynan  = (ye == 5'd31) && (op_q[9:0] != 10'd0);
        xbig  = {xe, sum_q[9:0]} >= {ye, op_q[9:0]};
        diff  = xbig ? xe - ye : ye - xe;
        sgn_d = xbig ? xs : ys;
        exp_d = xbig ? xe : ye;
        mb_d  = xbig ? xm : ym;
        ms_d  = (diff >= 5'd14) ? 11'd0 : (xbig ? ym : xm) >> diff;
        sub_d = xs ^ ys;
        spc_d = (xe == 5'd31) || (ye == 5'd31);
        spv_d = (xnan || ynan || (xe == 5'd31 && ye == 5'd31 && sum_q[15] != op_q[15])) ? 16'h7E00 :
                (xe == 5'd31) ? sum_q : op_q;
        add_d = sub_q ? {1'b0, mb_q} - {1'b0, ms_q} : {1'b0, mb_q} + {1'b0, ms_q};
    end

    // Normalisation: the leading one is moved to bit 11, so bits [10:1] are the truncated fraction.
    always_comb begin
        p = 4'd0;
        for (int i = 0; i < 12; i++) p = add_q[i] ? 4'(i) : p;
        nm  = add_q << (4'd11 - p);
        e_n = $signed({2'b00, exp_q}) + $signed({3'b000, p}) - 7'sd10;
        nv  = spc_q ? spv_q :
              (add_q == 12'd0 || e_n <= 7'sd0) ? 16'h0000 :
              (e_n >= 7'sd31) ? {sgn_q, OVF} : {sgn_q, e_n[4:0], nm[10:1]};
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        ready_d  = 1'b0;
        if (start) begin
            state_d = WAIT;
            sum_d   = 16'h0000;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                WAIT: begin
                    op_d    = en ? a : op_q;
                    state_d = en ? ALIGN : WAIT;
                end
                ALIGN: state_d = ADD;
                ADD:   state_d = NORM;
                NORM: begin
                    sum_d   = nv;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_d == LEN_C) ? DONE : WAIT;
                end
                DONE: begin
                    result_d = sum_q;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sum_q    <= 16'h0000;
            cnt_q    <= 8'd0;
            op_q     <= 16'h0000;
            result_q <= 16'h0000;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath pipeline registers; their contents only matter in the states that consume them.
    always_ff @(posedge clk) begin
        if (state_q == ALIGN) begin
            sgn_q <= sgn_d;
            exp_q <= exp_d;
            mb_q  <= mb_d;
            ms_q  <= ms_d;
            sub_q <= sub_d;
            spc_q <= spc_d;
            spv_q <= spv_d;
        end
        if (state_q == ADD) add_q <= add_d;
    end
endmodule

// File: tb/tb_floating_point_accumulator.sv
// tb_floating_point_accumulator: checks three accumulators (LEN = 2, 3, 4) against a behavioural model.
module tb_floating_point_accumulator;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, en = 1'b0;
    logic [15:0] a = 16'h0000;
    logic        ir [3];
    logic        rd [3];
    logic [15:0] res [3];
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;

`ifdef FP_ACC_SATURATE_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    always #5 clk = ~clk;

    // Reference FP16 addition: integer mantissas, truncating alignment shift, truncating normalisation.
    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, mx, my, sx, sy, eb, mb, ms, sb, d, r, e;
        bit xb;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        if ((ex == 31 && x[9:0] != 10'd0) || (ey == 31 && y[9:0] != 10'd0)) return 16'h7E00;
        if (ex == 31 && ey == 31) return (x[15] != y[15]) ? 16'h7E00 : x;
        if (ex == 31) return x;
        if (ey == 31) return y;
        mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
        my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
        sx = (ex == 0) ? 0 : int'(x[15]);
        sy = (ey == 0) ? 0 : int'(y[15]);
        xb = (ex > ey) || (ex == ey && mx >= my);
        eb = xb ? ex : ey;
        d  = xb ? ex - ey : ey - ex;
        mb = xb ? mx : my;
        ms = xb ? my : mx;
        sb = xb ? sx : sy;
        ms = (d >= 14) ? 0 : ms >> d;
        r  = (sx == sy) ? mb + ms : mb - ms;
        if (r == 0) return 16'h0000;
        e = eb;
        while (r >= 2048) begin r = r >> 1; e++; end
        while (r < 1024) begin r = r << 1; e--; end
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {sb[0], OVF_MAG};
        return {sb[0], e[4:0], r[9:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_len
        localparam int L = g + 2;
        logic [15:0] m_sum, m_res, m_op;
        int          m_cnt, m_t;
        bit          m_wait, m_rdy, m_fin;

        floating_point_accumulator #(.DATA_WIDTH(16), .LEN(L)) dut (
            .clk(clk), .reset(reset), .start(start), .en(en), .a(a),
            .in_ready(ir[g]), .result(res[g]), .ready(rd[g])
        );

        // m_t counts the edges still needed before an accepted operand lands in the sum.
        always @(posedge clk) begin
            m_rdy <= 1'b0;
            if (reset) begin
                m_sum <= 16'h0000; m_res <= 16'h0000; m_cnt <= 0; m_t <= 0; m_wait <= 1'b0; m_fin <= 1'b0;
            end else if (start) begin
                m_sum <= 16'h0000; m_cnt <= 0; m_t <= 0; m_wait <= 1'b1; m_fin <= 1'b0;
            end else if (m_fin) begin
                m_fin <= 1'b0; m_rdy <= 1'b1; m_res <= m_sum;
            end else if (m_t == 1) begin
                m_t   <= 0;
                m_sum <= fadd(m_sum, m_op);
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == L) m_fin <= 1'b1;
                else m_wait <= 1'b1;
            end else if (m_t > 1) begin
                m_t <= m_t - 1;
            end else if (m_wait && en) begin
                m_op <= a; m_wait <= 1'b0; m_t <= 3;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                checks += 3;
                if (ir[g] !== m_wait) begin
                    errors++;
                    $display("FAIL in_ready len=%0d t=%0t: got %b expected %b", L, $time, ir[g], m_wait);
                end
                if (rd[g] !== m_rdy) begin
                    errors++;
                    $display("FAIL ready len=%0d t=%0t: got %b expected %b", L, $time, rd[g], m_rdy);
                end
                if (res[g] !== m_res) begin
                    errors++;
                    $display("FAIL result len=%0d t=%0t: got %h expected %h", L, $time, res[g], m_res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int k, input logic [15:0] v);
        int n = 0;
        while (ir[k] !== 1'b1 && n < 40) begin tick(); n++; end
        if (ir[k] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL feed_timeout inst %0d: in_ready got %b expected 1", k, ir[k]);
        end
        en = 1'b1;
        a  = v;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_rdy(input int k, input logic [15:0] exp, input string name);
        int n = 0;
        while (rd[k] !== 1'b1 && n < 40) begin tick(); n++; end
        check({name, "_ready"}, 16'(rd[k]), 16'd1);
        check(name, res[k], exp);
    endtask

    function automatic logic [15:0] rand_fp();
        int k;
        logic [4:0] e;
        k = $urandom_range(0, 99);
        if (k < 50) e = 5'($urandom_range(12, 18));
        else if (k < 70) e = 5'($urandom_range(1, 30));
        else if (k < 80) e = 5'd0;
        else if (k < 94) e = 5'($urandom_range(27, 30));
        else e = 5'd31;
        return {1'($urandom), e, (k >= 94 && k < 97) ? 10'd0 : 10'($urandom)};
    endfunction

    initial begin
        int acc;
        logic [15:0] got;
        bit seen;
        repeat (3) tick();
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("reset_in_ready", 16'(ir[k]), 16'd0);
            check("reset_ready", 16'(rd[k]), 16'd0);
            check("reset_result", res[k], 16'h0000);
        end
        reset = 1'b0;
        tick();

        // 1.0 + 2.0 = 3.0, ready exactly on the 4th edge after the last accept
        pulse_start();
        feed(0, 16'h3C00);
        feed(0, 16'h4000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_latency", 16'(rd[0]), 16'd0);
        end
        tick();
        check("t1_ready", 16'(rd[0]), 16'd1);
        check("t1_result", res[0], 16'h4200);
        tick();
        check("t1_pulse", 16'(rd[0]), 16'd0);
        check("t1_hold", res[0], 16'h4200);

        // exact cancellation gives +0
        pulse_start();
        feed(0, 16'h3C00);
        feed(0, 16'hBC00);
        wait_rdy(0, 16'h0000, "t2_cancel");

        // en held high: in_ready gating must admit exactly four operands
        pulse_start();
        en = 1'b1;
        a = 16'h3800;
        acc = 0;
        seen = 1'b0;
        got = 16'hFFFF;
        for (int i = 0; i < 25; i++) begin
            if (ir[2] === 1'b1) acc++;
            tick();
            if (rd[2] === 1'b1) begin seen = 1'b1; got = res[2]; end
        end
        en = 1'b0;
        check("t3_accepts", 16'(acc), 16'd4);
        check("t3_ready_seen", 16'(seen), 16'd1);
        check("t3_result", got, 16'h4000);

        // overflow of two max-finite operands
        pulse_start();
        feed(0, 16'h7BFF);
        feed(0, 16'h7BFF);
        wait_rdy(0, {1'b0, OVF_MAG}, "t4_overflow");

        // NaN operand is sticky across later finite operands
        pulse_start();
        feed(1, 16'h7E00);
        feed(1, 16'h3C00);
        feed(1, 16'h4000);
        wait_rdy(1, 16'h7E00, "t5_nan");

        // reset while the second operand is in ADD discards everything
        pulse_start();
        feed(0, 16'h4000);
        feed(0, 16'h4000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t6_no_ready", 16'(rd[0]), 16'd0);
            tick();
        end
        check("t6_result_cleared", res[0], 16'h0000);
        pulse_start();
        feed(0, 16'h4000);
        feed(0, 16'h4000);
        wait_rdy(0, 16'h4400, "t6_after_reset");

        // randomized traffic, compared every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            start = !reset && ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 2) != 0);
            a     = rand_fp();
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        repeat (25) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
